// File: rtl/gate_sequence_accumulator.sv
// rtl/gate_sequence_accumulator.sv - folds a stream of 2x2 gates into a running product via an external multiplier
// Optional watchdog on the multiply phase: define GATE_SEQ_ACC_TIMEOUT_EN.
module gate_sequence_accumulator #(
  parameter int WIDTH     = 19,
  parameter int FRAC_BITS = 16,
  parameter int CNT_WIDTH = 8,
  parameter int TIMEOUT   = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     gate_r1c1,
  input  logic [WIDTH-1:0]     gate_r1c2,
  input  logic [WIDTH-1:0]     gate_r2c1,
  input  logic [WIDTH-1:0]     gate_r2c2,
  input  logic                 gate_valid,
  input  logic                 gate_last,
  output logic                 gate_ready,
  output logic [WIDTH-1:0]     mul_a_r1c1,
  output logic [WIDTH-1:0]     mul_a_r1c2,
  output logic [WIDTH-1:0]     mul_a_r2c1,
  output logic [WIDTH-1:0]     mul_a_r2c2,
  output logic [WIDTH-1:0]     mul_b_r1c1,
  output logic [WIDTH-1:0]     mul_b_r1c2,
  output logic [WIDTH-1:0]     mul_b_r2c1,
  output logic [WIDTH-1:0]     mul_b_r2c2,
  output logic                 mul_a_ready,
  output logic                 mul_b_ready,
  input  logic [WIDTH-1:0]     mul_r_r1c1,
  input  logic [WIDTH-1:0]     mul_r_r1c2,
  input  logic [WIDTH-1:0]     mul_r_r2c1,
  input  logic [WIDTH-1:0]     mul_r_r2c2,
  input  logic                 mul_completed,
  output logic [WIDTH-1:0]     res_r1c1,
  output logic [WIDTH-1:0]     res_r1c2,
  output logic [WIDTH-1:0]     res_r2c1,
  output logic [WIDTH-1:0]     res_r2c2,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [CNT_WIDTH-1:0] gate_count,
  output logic                 busy
`ifdef GATE_SEQ_ACC_TIMEOUT_EN
  ,
  output logic                 err_timeout
`endif
);

  typedef enum logic [1:0] {ACCEPT, MUL, DRAIN, DONE} state_t;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1} << FRAC_BITS;

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  state_t           state;
  logic [WIDTH-1:0] acc_r1c1, acc_r1c2, acc_r2c1, acc_r2c2;
  logic [WIDTH-1:0] g_r1c1, g_r1c2, g_r2c1, g_r2c2;
  logic             g_last;
  logic             mul_ready;

`ifdef GATE_SEQ_ACC_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt;
`endif

  // Accumulator and captured gate feed the multiplier and result ports directly.
  assign mul_a_r1c1  = acc_r1c1;
  assign mul_a_r1c2  = acc_r1c2;
  assign mul_a_r2c1  = acc_r2c1;
  assign mul_a_r2c2  = acc_r2c2;
  assign mul_b_r1c1  = g_r1c1;
  assign mul_b_r1c2  = g_r1c2;
  assign mul_b_r2c1  = g_r2c1;
  assign mul_b_r2c2  = g_r2c2;
  assign res_r1c1    = acc_r1c1;
  assign res_r1c2    = acc_r1c2;
  assign res_r2c1    = acc_r2c1;
  assign res_r2c2    = acc_r2c2;
  assign mul_a_ready = mul_ready;
  assign mul_b_ready = mul_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ACCEPT;
      acc_r1c1   <= ONE;
      acc_r1c2   <= '0;
      acc_r2c1   <= '0;
      acc_r2c2   <= ONE;
      g_r1c1     <= '0;
      g_r1c2     <= '0;
      g_r2c1     <= '0;
      g_r2c2     <= '0;
      g_last     <= 1'b0;
      gate_count <= '0;
      gate_ready <= 1'b1;
      mul_ready  <= 1'b0;
      res_valid  <= 1'b0;
      busy       <= 1'b0;
`ifdef GATE_SEQ_ACC_TIMEOUT_EN
      tmo_cnt     <= '0;
      err_timeout <= 1'b0;
`endif
    end else begin
      case (state)
        ACCEPT: begin
          if (gate_valid && gate_ready) begin
            g_r1c1     <= gate_r1c1;
            g_r1c2     <= gate_r1c2;
            g_r2c1     <= gate_r2c1;
            g_r2c2     <= gate_r2c2;
            g_last     <= gate_last;
            gate_ready <= 1'b0;
            mul_ready  <= 1'b1;
            busy       <= 1'b1;
            state      <= MUL;
`ifdef GATE_SEQ_ACC_TIMEOUT_EN
            tmo_cnt    <= '0;
`endif
          end
        end
        MUL: begin
          if (mul_completed) begin
            acc_r1c1  <= mul_r_r1c1;
            acc_r1c2  <= mul_r_r1c2;
            acc_r2c1  <= mul_r_r2c1;
            acc_r2c2  <= mul_r_r2c2;
            if (gate_count != {CNT_WIDTH{1'b1}})
              gate_count <= gate_count + 1'b1;
            mul_ready <= 1'b0;
            state     <= DRAIN;
          end
`ifdef GATE_SEQ_ACC_TIMEOUT_EN
          // Give up on this gate: accumulator untouched, sequence carries on.
          else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
            mul_ready   <= 1'b0;
            err_timeout <= 1'b1;
            state       <= DRAIN;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        DRAIN: begin
          // Wait out the completed flag so it is not mistaken for the next gate's.
          if (!mul_completed) begin
            if (g_last) begin
              res_valid <= 1'b1;
              state     <= DONE;
            end else begin
              gate_ready <= 1'b1;
              busy       <= 1'b0;
              state      <= ACCEPT;
            end
          end
        end
        DONE: begin
          if (res_ready) begin
            acc_r1c1   <= ONE;
            acc_r1c2   <= '0;
            acc_r2c1   <= '0;
            acc_r2c2   <= ONE;
            gate_count <= '0;
            res_valid  <= 1'b0;
            gate_ready <= 1'b1;
            busy       <= 1'b0;
            state      <= ACCEPT;
          end
        end
        default: begin
          state      <= ACCEPT;
          gate_ready <= 1'b1;
          mul_ready  <= 1'b0;
          res_valid  <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_sequence_accumulator.sv
// tb/tb_gate_sequence_accumulator.sv - self-checking bench for gate_sequence_accumulator
// Define GATE_SEQ_ACC_TIMEOUT_EN to also exercise the timeout path.
module tb_gate_sequence_accumulator;

  localparam int W  = 19;
  localparam int F  = 16;
  localparam int CW = 8;

  typedef logic [3:0][W-1:0] mat_t; // [0]=r1c1 [1]=r1c2 [2]=r2c1 [3]=r2c2

  logic clk = 1'b0;
  logic reset;
  logic [W-1:0] gate_r1c1, gate_r1c2, gate_r2c1, gate_r2c2;
  logic gate_valid, gate_last, gate_ready;
  logic [W-1:0] mul_a_r1c1, mul_a_r1c2, mul_a_r2c1, mul_a_r2c2;
  logic [W-1:0] mul_b_r1c1, mul_b_r1c2, mul_b_r2c1, mul_b_r2c2;
  logic mul_a_ready, mul_b_ready;
  logic [W-1:0] mul_r_r1c1, mul_r_r1c2, mul_r_r2c1, mul_r_r2c2;
  logic mul_completed;
  logic [W-1:0] res_r1c1, res_r1c2, res_r2c1, res_r2c2;
  logic res_valid, res_ready;
  logic [CW-1:0] gate_count;
  logic busy;
`ifdef GATE_SEQ_ACC_TIMEOUT_EN
  logic err_timeout;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  logic tie_low = 1'b0;

  gate_sequence_accumulator #(.WIDTH(W), .FRAC_BITS(F), .CNT_WIDTH(CW), .TIMEOUT(64)) dut (
    .clk(clk), .reset(reset),
    .gate_r1c1(gate_r1c1), .gate_r1c2(gate_r1c2), .gate_r2c1(gate_r2c1), .gate_r2c2(gate_r2c2),
    .gate_valid(gate_valid), .gate_last(gate_last), .gate_ready(gate_ready),
    .mul_a_r1c1(mul_a_r1c1), .mul_a_r1c2(mul_a_r1c2), .mul_a_r2c1(mul_a_r2c1), .mul_a_r2c2(mul_a_r2c2),
    .mul_b_r1c1(mul_b_r1c1), .mul_b_r1c2(mul_b_r1c2), .mul_b_r2c1(mul_b_r2c1), .mul_b_r2c2(mul_b_r2c2),
    .mul_a_ready(mul_a_ready), .mul_b_ready(mul_b_ready),
    .mul_r_r1c1(mul_r_r1c1), .mul_r_r1c2(mul_r_r1c2), .mul_r_r2c1(mul_r_r2c1), .mul_r_r2c2(mul_r_r2c2),
    .mul_completed(mul_completed),
    .res_r1c1(res_r1c1), .res_r1c2(res_r1c2), .res_r2c1(res_r2c1), .res_r2c2(res_r2c2),
    .res_valid(res_valid), .res_ready(res_ready),
    .gate_count(gate_count), .busy(busy)
`ifdef GATE_SEQ_ACC_TIMEOUT_EN
    , .err_timeout(err_timeout)
`endif
  );

  always #5 clk = ~clk;

  // Fixed-point 2x2 product with wraparound to W bits.
  function automatic logic [W-1:0] dot(logic [W-1:0] a0, logic [W-1:0] b0,
                                       logic [W-1:0] a1, logic [W-1:0] b1);
    longint s;
    s = longint'($signed(a0)) * longint'($signed(b0)) + longint'($signed(a1)) * longint'($signed(b1));
    s = s >>> F;
    return s[W-1:0];
  endfunction

  function automatic mat_t mm(mat_t a, mat_t b);
    mat_t r;
    r[0] = dot(a[0], b[0], a[1], b[2]);
    r[1] = dot(a[0], b[1], a[1], b[3]);
    r[2] = dot(a[2], b[0], a[3], b[2]);
    r[3] = dot(a[2], b[1], a[3], b[3]);
    return r;
  endfunction

  // Multiplier stand-in: completed and product follow the operand strobe by two cycles.
  mat_t am, bm, prod1, prod2;
  logic p1, comp_q;
  assign am = {mul_a_r2c2, mul_a_r2c1, mul_a_r1c2, mul_a_r1c1};
  assign bm = {mul_b_r2c2, mul_b_r2c1, mul_b_r1c2, mul_b_r1c1};
  always_ff @(posedge clk) begin
    if (reset) begin
      p1 <= 1'b0; comp_q <= 1'b0; prod1 <= '0; prod2 <= '0;
    end else begin
      p1 <= mul_a_ready & mul_b_ready;
      comp_q <= p1;
      prod1 <= mm(am, bm);
      prod2 <= prod1;
    end
  end
  assign mul_completed = comp_q & ~tie_low;
  assign {mul_r_r2c2, mul_r_r2c1, mul_r_r1c2, mul_r_r1c1} = prod2;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic mat_t mk(int a, int b, int c, int d);
    mat_t m;
    m[0] = W'(a); m[1] = W'(b); m[2] = W'(c); m[3] = W'(d);
    return m;
  endfunction

  // Offer a gate until accepted; checks the operands presented in the first MUL cycle.
  task automatic send_gate(input mat_t g, input logic last, input mat_t acc);
    int guard = 0;
    {gate_r2c2, gate_r2c1, gate_r1c2, gate_r1c1} = g;
    gate_last = last;
    gate_valid = 1'b1;
    while (!gate_ready && guard < 60) begin tick(); guard++; end
    chk("gate_ready_wait", {31'd0, gate_ready}, 32'd1);
    tick();
    gate_valid = 1'b0;
    gate_last = 1'b0;
    chk("mul_ready_a", {31'd0, mul_a_ready}, 32'd1);
    chk("mul_ready_b", {31'd0, mul_b_ready}, 32'd1);
    chk("gate_ready_in_mul", {31'd0, gate_ready}, 32'd0);
    chk("busy_in_mul", {31'd0, busy}, 32'd1);
    chk("mul_a", {13'd0, am[1:0]}, {13'd0, acc[1:0]});
    chk("mul_a_hi", {13'd0, am[3:2]}, {13'd0, acc[3:2]});
    chk("mul_b", {13'd0, bm[1:0]}, {13'd0, g[1:0]});
    chk("mul_b_hi", {13'd0, bm[3:2]}, {13'd0, g[3:2]});
  endtask

  task automatic wait_accept();
    int guard = 0;
    while (!gate_ready && guard < 60) begin tick(); guard++; end
    chk("next_gate_ready", {31'd0, gate_ready}, 32'd1);
  endtask

  task automatic check_res(input string tag, input mat_t exp, input int cnt);
    int guard = 0;
    while (!res_valid && guard < 60) begin tick(); guard++; end
    chk({tag, "_valid"}, {31'd0, res_valid}, 32'd1);
    chk({tag, "_r1c1"}, {13'd0, res_r1c1}, {13'd0, exp[0]});
    chk({tag, "_r1c2"}, {13'd0, res_r1c2}, {13'd0, exp[1]});
    chk({tag, "_r2c1"}, {13'd0, res_r2c1}, {13'd0, exp[2]});
    chk({tag, "_r2c2"}, {13'd0, res_r2c2}, {13'd0, exp[3]});
    chk({tag, "_count"}, {24'd0, gate_count}, 32'(cnt));
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk({tag, "_valid_drop"}, {31'd0, res_valid}, 32'd0);
    chk({tag, "_ready_back"}, {31'd0, gate_ready}, 32'd1);
  endtask

  initial begin
    mat_t ident, xg, zg, exp, g;
    int n, vals[5];
    vals = '{-65536, -32768, 0, 32768, 65536};
    ident = mk(65536, 0, 0, 65536);
    xg = mk(0, 65536, 65536, 0);
    zg = mk(65536, 0, 0, -65536);
    reset = 1'b1; gate_valid = 1'b0; gate_last = 1'b0; res_ready = 1'b0;
    {gate_r2c2, gate_r2c1, gate_r1c2, gate_r1c1} = '0;
    repeat (3) tick();
    reset = 1'b0;

    chk("rst_gate_ready", {31'd0, gate_ready}, 32'd1);
    chk("rst_mul_ready", {30'd0, mul_a_ready, mul_b_ready}, 32'd0);
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_count", {24'd0, gate_count}, 32'd0);
    chk("rst_acc", {13'd0, res_r1c1, res_r2c2}, {13'd0, 19'd65536, 19'd65536});
    chk("rst_acc_off", {13'd0, res_r1c2, res_r2c1}, 32'd0);
    chk("rst_gate_regs", {13'd0, bm[1:0]}, 32'd0);
`ifdef GATE_SEQ_ACC_TIMEOUT_EN
    chk("rst_err_timeout", {31'd0, err_timeout}, 32'd0);
`endif

    // Single identity gate: result at cycle 7 after the handshake.
    send_gate(ident, 1'b1, ident);
    n = 1;
    while (!res_valid && n < 40) begin
      chk("no_early_ready", {31'd0, gate_ready}, 32'd0);
      tick(); n++;
    end
    chk("latency_cycles", 32'(n), 32'd7);
    check_res("single", ident, 1);

    send_gate(xg, 1'b0, ident);
    wait_accept();
    send_gate(xg, 1'b1, xg);
    check_res("xx", ident, 2);

    send_gate(xg, 1'b0, ident);
    wait_accept();
    send_gate(zg, 1'b1, xg);
    check_res("xz", mk(0, -65536, 65536, 0), 2);

    // Result held while the consumer stalls; a pending gate waits.
    send_gate(xg, 1'b1, ident);
    n = 0;
    while (!res_valid && n < 40) begin tick(); n++; end
    {gate_r2c2, gate_r2c1, gate_r1c2, gate_r1c1} = zg;
    gate_last = 1'b1;
    gate_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("hold_valid", {31'd0, res_valid}, 32'd1);
      chk("hold_gate_ready", {31'd0, gate_ready}, 32'd0);
      chk("hold_res", {13'd0, res_r1c1, res_r1c2}, {13'd0, xg[0], xg[1]});
      chk("hold_res_hi", {13'd0, res_r2c1, res_r2c2}, {13'd0, xg[2], xg[3]});
      tick();
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    send_gate(zg, 1'b1, ident);
    check_res("after_hold", zg, 1);

    // Reset in the middle of a multiply after one gate has been folded in.
    send_gate(xg, 1'b0, ident);
    wait_accept();
    send_gate(zg, 1'b0, xg);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_gate_ready", {31'd0, gate_ready}, 32'd1);
    chk("midrst_mul_ready", {30'd0, mul_a_ready, mul_b_ready}, 32'd0);
    chk("midrst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("midrst_count", {24'd0, gate_count}, 32'd0);
    chk("midrst_acc", {13'd0, res_r1c1, res_r1c2}, {13'd0, 19'd65536, 19'd0});
    chk("midrst_acc_hi", {13'd0, res_r2c1, res_r2c2}, {13'd0, 19'd0, 19'd65536});

    // Random sequences against the composed reference product.
    for (int s = 0; s < 8; s++) begin
      n = $urandom_range(1, 4);
      exp = ident;
      for (int i = 0; i < n; i++) begin
        g = mk(vals[$urandom_range(0, 4)], vals[$urandom_range(0, 4)],
               vals[$urandom_range(0, 4)], vals[$urandom_range(0, 4)]);
        send_gate(g, i == n - 1, exp);
        exp = mm(exp, g);
        if (i != n - 1) wait_accept();
      end
      check_res("rand", exp, n);
    end

`ifdef GATE_SEQ_ACC_TIMEOUT_EN
    send_gate(xg, 1'b0, ident);
    wait_accept();
    tie_low = 1'b1;
    send_gate(zg, 1'b0, xg);
    n = 1;
    while (mul_a_ready && n < 200) begin tick(); n++; end
    chk("tmo_mul_cycles", 32'(n), 32'd65);
    chk("tmo_err", {31'd0, err_timeout}, 32'd1);
    wait_accept();
    repeat (4) tick();
    tie_low = 1'b0;
    send_gate(ident, 1'b1, xg);
    check_res("tmo_acc_kept", xg, 2);
    chk("tmo_sticky", {31'd0, err_timeout}, 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/gate_sequence_accumulator.md
Name: gate_sequence_accumulator

Overview:
- Controller directly upstream of, and wrapped around, the 2x2 fixed-point matrix_multiplier.
- Accepts a stream of 2x2 gate matrices and drives the multiplier with (running product, next gate).
- Writes each product back into the accumulator.
- When the gate flagged last has been folded in, presents the composite unitary on a valid/ready output.

Parameters:
- WIDTH, 19, element width; signed fixed point, must match matrix_multiplier.
- FRAC_BITS, 16, fractional bits; identity diagonal value is 1<<FRAC_BITS.
- CNT_WIDTH, 8, width of the gate counter.
- TIMEOUT, 64, cycles allowed in MUL before error; used only with the optional feature.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- gate_r1c1, gate_r1c2, gate_r2c1, gate_r2c2  in  WIDTH each  incoming gate elements.
- gate_valid  in  1  gate word present.
- gate_last  in  1  final gate of the sequence; qualified by gate_valid.
- gate_ready  out  1  block can accept a gate.
- mul_a_r1c1, mul_a_r1c2, mul_a_r2c1, mul_a_r2c2  out  WIDTH each  accumulator to multiplier A.
- mul_b_r1c1, mul_b_r1c2, mul_b_r2c1, mul_b_r2c2  out  WIDTH each  captured gate to multiplier B.
- mul_a_ready, mul_b_ready  out  1 each  operand-valid strobes to the multiplier; always driven equal.
- mul_r_r1c1, mul_r_r1c2, mul_r_r2c1, mul_r_r2c2  in  WIDTH each  product from the multiplier.
- mul_completed  in  1  multiplier completed flag.
- res_r1c1, res_r1c2, res_r2c1, res_r2c2  out  WIDTH each  composite matrix, driven from the accumulator.
- res_valid  out  1  composite available.
- res_ready  in  1  consumer accepts the composite.
- gate_count  out  CNT_WIDTH  gates folded into the current sequence; saturates at all-ones.
- busy  out  1  high in every state except ACCEPT.

Behaviour:
- Reset values:
  - state = ACCEPT.
  - Accumulator = identity: r1c1 = r2c2 = 1<<FRAC_BITS, off-diagonals = 0.
  - Gate registers = 0; gate_count = 0.
  - gate_ready = 1; mul_*_ready = 0; res_valid = 0; busy = 0.
- Reset is honoured in any state. A mid-MUL reset abandons the operation; the multiplier is reset by the same signal.
- State ACCEPT:
  - gate_ready = 1.
  - On gate_valid & gate_ready: capture the four gate elements and gate_last into registers, then go to MUL.
- State MUL:
  - mul_a = accumulator, mul_b = captured gate; mul_a_ready = mul_b_ready = 1.
  - Operands are held stable for the whole state.
  - On the first cycle mul_completed = 1: load the accumulator from mul_r_*, increment gate_count (saturating), drop both readies the next cycle, go to DRAIN.
  - Product order is acc × gate (right-multiply).
- State DRAIN:
  - Readies low; wait until mul_completed = 0. This prevents a stale completed flag being taken for the next gate.
  - Then: if the captured last flag is 1, go to DONE; else go to ACCEPT.
- State DONE:
  - res_valid = 1; res_* = accumulator, held stable until the handshake.
  - On res_ready: reset the accumulator to identity, clear gate_count, go to ACCEPT.
  - res_valid does not drop without res_ready.
- gate_ready is 0 outside ACCEPT. Gates offered in other states stall; they are not dropped.
- Latency with matrix_multiplier (2-cycle completed):
  - Gate handshake at cycle 0 → readies at cycle 1 → completed seen at cycle 3 → accumulator updated at cycle 4 edge → DRAIN exits at cycle 7.
  - Next gate_ready at cycle 7, or res_valid at cycle 7 for a last gate.
- Arithmetic: no internal math. Accumulator width is WIDTH; overflow behaviour belongs to the multiplier.

Optional Feature:
- Macro: GATE_SEQ_ACC_TIMEOUT_EN.
- When defined:
  - A counter runs in MUL. If TIMEOUT cycles elapse without mul_completed, the block drops the readies, sets sticky output err_timeout = 1 and goes to DRAIN.
  - The accumulator is unchanged and the gate is discarded; the sequence continues.
  - err_timeout clears only on reset.
- When undefined: no counter, no err_timeout port, and MUL waits indefinitely.

Test Plan:
- Single gate G = [[65536,0],[0,65536]] with gate_last = 1 → res_valid at cycle 7; res = identity; gate_count = 1.
- Gates X = [[0,65536],[65536,0]] then X (last) → res = identity (r1c1 = r2c2 = 65536); gate_count = 2; gate_ready low between the gates.
- Gates X then Z = [[65536,0],[0,-65536]] (last) → res = X·Z = [[0,-65536],[65536,0]] in 19-bit two's complement.
- Hold res_ready = 0 for 10 cycles after res_valid → res_* stable, gate_ready = 0, gate_valid stalls; on res_ready, the next sequence starts from identity.
- Assert reset during MUL (cycle 2) → the next cycle shows gate_ready = 1, readies = 0, res_valid = 0, accumulator = identity.
- With GATE_SEQ_ACC_TIMEOUT_EN: tie mul_completed = 0 → err_timeout = 1 after 64 MUL cycles; returns to ACCEPT; accumulator unchanged.
